// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the CNN frame sequencer and its watchdog.
// Layer engines are sequenced strictly in index order, one at a time.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    GAP,
    OUT,
    ERR
  } seq_state_t;

  localparam int          NUM_LAYERS_DEF = 3;
  localparam int          CNT_W_DEF      = 24;

  // Worst-case run budgets per engine; the sequencer uses the largest as its single limit.
  localparam int unsigned TIMEOUT_CONV2D_0 = 32'd2000000;
  localparam int unsigned TIMEOUT_CONV2D_1 = 32'd2000000;
  localparam int unsigned TIMEOUT_DENSE    = 32'd500000;
  localparam int unsigned TIMEOUT_DEF      = TIMEOUT_CONV2D_0;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LAYER_IDX_W = idx_w(NUM_LAYERS_DEF);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer run-time watchdog: counts enabled cycles after a clear and flags
// expiry once TIMEOUT cycles have elapsed; holds at the limit.
module layer_watchdog #(
  parameter int          CNT_W   = 24,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame-level controller: accepts a frame, runs each layer engine in turn via
// level start/done, flips the ping-pong buffer between layers, reports latency.
module cnn_layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int          NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int          CNT_W      = CNT_W_DEF,
  localparam int         IDX_W      = idx_w(NUM_LAYERS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic                  abort,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  buf_sel,
  output logic [IDX_W-1:0]      cur_layer,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic                  error,
  output logic [31:0]           frame_cycles
);

  seq_state_t            state_q, state_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic                  buf_sel_q, buf_sel_d;
  logic [NUM_LAYERS-1:0] start_q, start_d;
  logic                  done_prev_q, done_prev_d;
  logic                  err_q, err_d;
  logic [31:0]           cyc_q, cyc_d;
  logic [31:0]           frame_cycles_q, frame_cycles_d;

  logic wd_clear, wd_en, wd_expired;
  logic cur_done, done_edge;

  layer_watchdog #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_expired)
  );

  // Engines may leave done high after finishing, so only a fresh rise counts.
  assign cur_done  = layer_done[cur_q];
  assign done_edge = cur_done & ~done_prev_q;

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    buf_sel_d      = buf_sel_q;
    start_d        = start_q;
    done_prev_d    = done_prev_q;
    err_d          = err_q;
    cyc_d          = cyc_q;
    frame_cycles_d = frame_cycles_q;
    wd_clear       = 1'b0;
    wd_en          = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          state_d   = LAUNCH;
          cur_d     = '0;
          buf_sel_d = 1'b0;
          cyc_d     = '0;
        end
      end
      LAUNCH: begin
        done_prev_d = cur_done;
        start_d     = NUM_LAYERS'(1) << cur_q;
        wd_clear    = 1'b1;
        cyc_d       = sat_inc32(cyc_q);
        state_d     = RUN;
      end
      RUN: begin
        done_prev_d = cur_done;
        wd_en       = 1'b1;
        cyc_d       = sat_inc32(cyc_q);
        if (done_edge) begin
          start_d = '0;
          state_d = GAP;
        end else if (wd_expired) begin
          start_d = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      GAP: begin
        cyc_d = sat_inc32(cyc_q);
        if (cur_q == IDX_W'(NUM_LAYERS - 1)) begin
          // Latency includes the cycle that enters OUT.
          frame_cycles_d = sat_inc32(cyc_q);
          state_d        = OUT;
        end else begin
          cur_d     = cur_q + IDX_W'(1);
          buf_sel_d = ~buf_sel_q;
          state_d   = LAUNCH;
        end
      end
      OUT: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything decided above; buffer select and latency are kept.
    if (abort) begin
      state_d        = IDLE;
      start_d        = '0;
      err_d          = 1'b0;
      cur_d          = cur_q;
      buf_sel_d      = buf_sel_q;
      frame_cycles_d = frame_cycles_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cur_q          <= '0;
      buf_sel_q      <= 1'b0;
      start_q        <= '0;
      done_prev_q    <= 1'b0;
      err_q          <= 1'b0;
      cyc_q          <= '0;
      frame_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      buf_sel_q      <= buf_sel_d;
      start_q        <= start_d;
      done_prev_q    <= done_prev_d;
      err_q          <= err_d;
      cyc_q          <= cyc_d;
      frame_cycles_q <= frame_cycles_d;
    end
  end

  assign frame_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == OUT);
  assign error        = err_q;
  assign layer_start  = start_q;
  assign buf_sel      = buf_sel_q;
  assign cur_layer    = cur_q;
  assign frame_cycles = frame_cycles_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer with simple engine models that raise
// done a programmable number of cycles after their start rises.
module tb_cnn_layer_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic        frame_ready;
  logic        abort;
  logic [2:0]  layer_start;
  logic [2:0]  layer_done;
  logic        buf_sel;
  logic [1:0]  cur_layer;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        error;
  logic [31:0] frame_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int dly [3];
  int ecnt [3];
  logic [2:0] auto_en;
  logic [2:0] man_done;

  cnn_layer_sequencer #(
    .NUM_LAYERS(3),
    .TIMEOUT   (100),
    .CNT_W     (24)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .abort       (abort),
    .layer_start (layer_start),
    .layer_done  (layer_done),
    .buf_sel     (buf_sel),
    .cur_layer   (cur_layer),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy),
    .error       (error),
    .frame_cycles(frame_cycles)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Engine model: counts cycles its start has been high; auto mode pulses done
  // once start has been high for dly cycles.
  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      ecnt[i] <= layer_start[i] ? ecnt[i] + 1 : 0;
    end
  end

  always_comb begin
    layer_done = '0;
    for (int i = 0; i < 3; i++) begin
      layer_done[i] = auto_en[i] ? (ecnt[i] == dly[i] + 1) : man_done[i];
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic accept_frame();
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_start(input logic [2:0] pat, input int maxc, input string tag, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (layer_start === pat) begin
        at = cyc - t0;
        break;
      end
    end
    chk(tag, 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_rv(input int maxc, input string tag, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (result_valid === 1'b1) begin
        at = cyc - t0;
        break;
      end
    end
    chk(tag, 32'(at >= 0), 32'd1);
  endtask

  int at;
  logic [2:0] seen;

  initial begin
    reset        = 1'b1;
    frame_valid  = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b1;
    auto_en      = 3'b111;
    man_done     = 3'b000;
    dly          = '{5, 5, 5};
    step(2);
    chk("rst_frame_ready", 32'(frame_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(layer_start), 32'd0);
    chk("rst_buf_sel", 32'(buf_sel), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_frame_cycles", frame_cycles, 32'd0);
    chk("rst_cur_layer", 32'(cur_layer), 32'd0);
    reset = 1'b0;
    step(1);

    // 1: asynchronous reset while layer 1 runs
    accept_frame();
    wait_start(3'b010, 40, "t1_start1_seen", at);
    chk("t1_start1_cycle", 32'(at), 32'd9);
    chk("t1_cur_layer", 32'(cur_layer), 32'd1);
    chk("t1_buf_sel", 32'(buf_sel), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_start", 32'(layer_start), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    chk("t1_async_frame_ready", 32'(frame_ready), 32'd1);
    chk("t1_async_buf_sel", 32'(buf_sel), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);

    // 2: engines finish 50/80/20 cycles after start, result taken at once
    dly = '{50, 80, 20};
    accept_frame();
    chk("t2_busy_after_accept", 32'(busy), 32'd1);
    chk("t2_no_start_yet", 32'(layer_start), 32'd0);
    step(1);
    chk("t2_start0", 32'(layer_start), 32'd1);
    chk("t2_buf_sel0", 32'(buf_sel), 32'd0);
    wait_start(3'b010, 200, "t2_start1_seen", at);
    chk("t2_start1_cycle", 32'(at), 32'd54);
    chk("t2_buf_sel1", 32'(buf_sel), 32'd1);
    wait_start(3'b100, 200, "t2_start2_seen", at);
    chk("t2_start2_cycle", 32'(at), 32'd137);
    chk("t2_buf_sel2", 32'(buf_sel), 32'd0);
    chk("t2_cur_layer2", 32'(cur_layer), 32'd2);
    wait_rv(100, "t2_rv_seen", at);
    chk("t2_rv_cycle", 32'(at), 32'd159);
    chk("t2_frame_cycles", frame_cycles, 32'd159);
    step(1);
    chk("t2_idle_busy", 32'(busy), 32'd0);
    chk("t2_idle_rv", 32'(result_valid), 32'd0);

    // 3: layer 1 done stuck high before launch; only the later rise counts
    dly      = '{5, 5, 5};
    auto_en  = 3'b101;
    man_done = 3'b010;
    accept_frame();
    wait_start(3'b010, 40, "t3_start1_seen", at);
    step(10);
    chk("t3_stuck_ignored", 32'(layer_start), 32'd2);
    man_done = 3'b000;
    step(20);
    chk("t3_still_running", 32'(layer_start), 32'd2);
    man_done = 3'b010;
    chk("t3_before_rise", 32'(layer_start), 32'd2);
    step(1);
    chk("t3_exit_start", 32'(layer_start), 32'd0);
    chk("t3_exit_cur", 32'(cur_layer), 32'd1);
    wait_start(3'b100, 10, "t3_start2_seen", at);
    chk("t3_start2_cycle", 32'(at), 32'd42);
    wait_rv(40, "t3_rv_seen", at);
    chk("t3_frame_cycles", frame_cycles, 32'd49);
    step(1);
    man_done = 3'b000;
    auto_en  = 3'b111;
    step(1);

    // 4: layer 0 never finishes with TIMEOUT=100
    auto_en = 3'b110;
    accept_frame();
    step(100);
    chk("t4_no_error_yet", 32'(error), 32'd0);
    chk("t4_start_held", 32'(layer_start), 32'd1);
    step(1);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_start_dropped", 32'(layer_start), 32'd0);
    chk("t4_frame_ready", 32'(frame_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    frame_valid = 1'b1;
    step(3);
    chk("t4_err_sticky", 32'(error), 32'd1);
    chk("t4_err_no_accept", 32'(frame_ready), 32'd0);
    frame_valid = 1'b0;
    abort       = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_error", 32'(error), 32'd0);
    chk("t4_abort_ready", 32'(frame_ready), 32'd1);
    auto_en = 3'b111;
    step(1);

    // 5: consumer stalls 10 cycles; new frames ignored meanwhile
    dly          = '{3, 3, 3};
    result_ready = 1'b0;
    accept_frame();
    wait_rv(40, "t5_rv_seen", at);
    chk("t5_rv_cycle", 32'(at), 32'd18);
    chk("t5_frame_cycles", frame_cycles, 32'd18);
    frame_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("t5_rv_hold_%0d", i), 32'(result_valid), 32'd1);
    end
    chk("t5_not_ready", 32'(frame_ready), 32'd0);
    chk("t5_no_new_start", 32'(layer_start), 32'd0);
    frame_valid  = 1'b0;
    result_ready = 1'b1;
    step(1);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_rv", 32'(result_valid), 32'd0);
    step(1);

    // 6: abort and a layer 1 done edge in the same cycle
    auto_en  = 3'b101;
    man_done = 3'b000;
    accept_frame();
    wait_start(3'b010, 40, "t6_start1_seen", at);
    step(3);
    man_done = 3'b010;
    abort    = 1'b1;
    step(1);
    abort    = 1'b0;
    man_done = 3'b000;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_start", 32'(layer_start), 32'd0);
    chk("t6_rv", 32'(result_valid), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_ready", 32'(frame_ready), 32'd1);
    chk("t6_buf_sel_kept", 32'(buf_sel), 32'd1);
    chk("t6_frame_cycles_kept", frame_cycles, 32'd18);
    seen = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen = seen | layer_start;
    end
    chk("t6_no_more_starts", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
